// File: rtl/rt_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rt_counter_if
//  Purpose  : Bundles the count-enable / clear controls and the count / carry
//             results of one rt_counter stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface rt_counter_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] count;
  logic             carry_out;

  // Controller side: drives the controls, observes the count.
  modport master (
    output enable,
    output clear,
    input  count,
    input  carry_out
  );

  // Counter side: receives the controls, produces the count.
  modport slave (
    input  enable,
    input  clear,
    output count,
    output carry_out
  );
endinterface : rt_counter_if
`default_nettype wire

// File: rtl/rt_counter.sv
`default_nettype none
// ============================================================================
//  Module   : rt_counter
//  Purpose  : Up-counter with count-enable, synchronous clear and a one-cycle
//             registered carry pulse on the MAX_COUNT -> 0 wrap. Stages can be
//             cascaded by feeding carry_out into the next stage's enable.
//  Revision : 1.0 - initial release
// ============================================================================
module rt_counter #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  wire logic    clk,
  input  wire logic    rstn,
  rt_counter_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             carry_q;
  logic             carry_d;

  // Next-state: clear beats enable; the wrap is the only source of carry, so
  // a held or cleared counter never pulses carry.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.enable) begin
      if (count_q == MAX_COUNT) begin
        count_d = '0;
        carry_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State registers; reset clears both outputs immediately, cutting short any
  // carry pulse that is in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  // Outputs come straight from flops: no input-to-output combinational path.
  assign bus.count     = count_q;
  assign bus.carry_out = carry_q;

endmodule : rt_counter
`default_nettype wire

// File: tb/tb_rt_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rt_counter
//  Purpose  : Directed self-checking bench for rt_counter. Two 16-bit stages
//             share one long free-run so both reach 16'hFFFF together; a
//             4-bit stage with MAX_COUNT=9 exercises a non-power-of-two wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rt_counter;

  logic clk;
  logic rstn;

  int n_cmp;
  int n_err;
  int carries_a;
  int carries_b;

  rt_counter_if #(.WIDTH(16)) ifa ();
  rt_counter_if #(.WIDTH(16)) ifb ();
  rt_counter_if #(.WIDTH(4))  ifc ();

  rt_counter #(.WIDTH(16)) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifa)
  );

  rt_counter #(.WIDTH(16)) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifb)
  );

  rt_counter #(.WIDTH(4), .MAX_COUNT(4'd9)) dut_c (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    carries_a  = 0;
    carries_b  = 0;
    rstn       = 1'b0;
    ifa.enable = 1'b1;
    ifa.clear  = 1'b0;
    ifb.enable = 1'b0;
    ifb.clear  = 1'b0;
    ifc.enable = 1'b0;
    ifc.clear  = 1'b0;

    // Reset held with enable high: outputs stay at zero even across an edge.
    #1;
    chk("rst_count", 32'(ifa.count), 32'h0);
    chk("rst_carry", 32'(ifa.carry_out), 32'h0);
    step();
    chk("rst_count_edge", 32'(ifa.count), 32'h0);
    #4 rstn = 1'b1;

    // Counting starts on the first edge after release.
    step(); chk("run_1", 32'(ifa.count), 32'h1);
    step(); chk("run_2", 32'(ifa.count), 32'h2);
    step(); chk("run_3", 32'(ifa.count), 32'h3);
    step();
    step(); chk("run_5", 32'(ifa.count), 32'h5);

    // One disabled edge holds the value, then counting resumes.
    ifa.enable = 1'b0;
    step(); chk("hold_5", 32'(ifa.count), 32'h5);
    chk("hold_carry", 32'(ifa.carry_out), 32'h0);
    ifa.enable = 1'b1;
    step(); chk("resume_6", 32'(ifa.count), 32'h6);
    for (int i = 0; i < 5; i++) step();
    chk("run_11", 32'(ifa.count), 32'hB);

    // Clear with enable high wins.
    ifa.clear = 1'b1;
    step(); chk("clear_0", 32'(ifa.count), 32'h0);
    chk("clear_carry", 32'(ifa.carry_out), 32'h0);
    ifa.clear = 1'b0;
    step(); chk("after_clear_1", 32'(ifa.count), 32'h1);
    step(); chk("after_clear_2", 32'(ifa.count), 32'h2);

    // Bring A and B to zero together, then free-run both to 16'hFFFF.
    ifa.clear = 1'b1;
    ifb.clear = 1'b1;
    step();
    ifa.clear  = 1'b0;
    ifb.clear  = 1'b0;
    ifb.enable = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      step();
      if (ifa.carry_out !== 1'b0) carries_a++;
      if (ifb.carry_out !== 1'b0) carries_b++;
    end
    chk("a_at_max", 32'(ifa.count), 32'hFFFF);
    chk("b_at_max", 32'(ifb.count), 32'hFFFF);
    chk("a_no_early_carry", 32'(carries_a), 32'h0);
    chk("b_no_early_carry", 32'(carries_b), 32'h0);

    // A: enable dropped at max holds without carry.
    // B: clear together with enable at max gives zero and no carry.
    ifa.enable = 1'b0;
    ifb.clear  = 1'b1;
    step();
    chk("a_hold_max", 32'(ifa.count), 32'hFFFF);
    chk("a_hold_max_carry", 32'(ifa.carry_out), 32'h0);
    chk("b_clear_at_max", 32'(ifb.count), 32'h0);
    chk("b_clear_at_max_carry", 32'(ifb.carry_out), 32'h0);
    ifb.clear = 1'b0;
    step();
    chk("a_hold_max_2", 32'(ifa.count), 32'hFFFF);
    chk("b_after_clear_1", 32'(ifb.count), 32'h1);
    chk("b_after_clear_carry", 32'(ifb.carry_out), 32'h0);

    // A: re-enable wraps with a single-cycle carry.
    ifa.enable = 1'b1;
    step();
    chk("a_wrap_0", 32'(ifa.count), 32'h0);
    chk("a_wrap_carry", 32'(ifa.carry_out), 32'h1);
    step();
    chk("a_post_wrap_1", 32'(ifa.count), 32'h1);
    chk("a_post_wrap_carry", 32'(ifa.carry_out), 32'h0);

    // Asynchronous reset asserted between edges takes effect immediately.
    step();
    step();
    step();
    chk("a_pre_reset_4", 32'(ifa.count), 32'h4);
    #2 rstn = 1'b0;
    #1;
    chk("a_async_rst", 32'(ifa.count), 32'h0);
    chk("b_async_rst", 32'(ifb.count), 32'h0);
    #3 rstn = 1'b1;
    step();
    chk("a_after_rst_1", 32'(ifa.count), 32'h1);

    // C: modulo-10 wrap, then reset truncates the carry pulse.
    ifc.enable = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("c_at_9", 32'(ifc.count), 32'h9);
    chk("c_at_9_carry", 32'(ifc.carry_out), 32'h0);
    step();
    chk("c_wrap_0", 32'(ifc.count), 32'h0);
    chk("c_wrap_carry", 32'(ifc.carry_out), 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("c_carry_truncated", 32'(ifc.carry_out), 32'h0);
    #3 rstn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rt_counter
`default_nettype wire
